game_redo: RTL and testbench

//  Redo stack paired with game_retract (3-deep undo history). It captures every state discarded by a real retract
//  and replays those states, newest first, on request through a request/valid/ack handshake.

---
 rtl/game_redo.sv | 92 +++++++++
 tb/tb_game_redo.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/game_redo.sv
// Redo stack beside game_retract: keeps states discarded by real retracts and
// replays them newest-first through a req/valid/ack handshake.
module game_redo #(
   parameter int N     = 134,
   parameter int DEPTH = 3,
   parameter int CW    = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          game_state_en,
   input  logic [1:0]    sel,
   input  logic          real_retract,
   input  logic [N-1:0]  game_state_now,
   input  logic          redo_req,
   input  logic          redo_ack,
   output logic [N-1:0]  redo_state,
   output logic          redo_valid,
   output logic          redo_nack,
   output logic [CW-1:0] redo_count
);

   typedef enum logic {S_IDLE = 1'b0, S_PRESENT = 1'b1} state_t;

   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   state_t                     r_state;
   logic [DEPTH-1:0][N-1:0]    r_stack;
   logic [CW-1:0]              r_count;
   logic                       r_valid;
   logic                       r_nack;

   logic w_move, w_push, w_pop, w_clear;

   assign w_move  = (sel == 2'd1) || (sel == 2'd2);
   assign w_push  = game_state_en && (sel == 2'd3) && real_retract;
   // An ack only pops while the top entry is actually being presented.
   assign w_pop   = game_state_en && w_move && redo_ack && (r_state == S_PRESENT);
   assign w_clear = game_state_en && ((sel == 2'd0) || (w_move && !w_pop));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_stack <= '0;
         r_count <= '0;
         r_valid <= 1'b0;
         r_nack  <= 1'b0;
      end else begin
         r_nack <= 1'b0;

         if (w_push) begin
            r_stack[0] <= game_state_now;
            for (int i = 1; i < DEPTH; i++) r_stack[i] <= r_stack[i-1];
            if (r_count != FULL) r_count <= r_count + 1'b1;
         end else if (w_pop) begin
            for (int i = 0; i < DEPTH-1; i++) r_stack[i] <= r_stack[i+1];
            r_stack[DEPTH-1] <= '0;
            r_count <= r_count - 1'b1;
         end else if (w_clear) begin
            r_stack <= '0;
            r_count <= '0;
         end

         case (r_state)
            S_IDLE: begin
               if (redo_req && (r_count != '0)) begin
                  r_state <= S_PRESENT;
                  r_valid <= 1'b1;
               end else if (redo_req) begin
                  r_nack <= 1'b1;
               end
            end
            S_PRESENT: begin
               // A push keeps presenting; redo_state simply tracks the new top.
               if (w_pop || w_clear) begin
                  r_state <= S_IDLE;
                  r_valid <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign redo_state = r_stack[0];
   assign redo_valid = r_valid;
   assign redo_nack  = r_nack;
   assign redo_count = r_count;

endmodule

// File: tb/tb_game_redo.sv
// Scoreboard bench for game_redo: each step queues its expected outputs, then
// pops and compares them one cycle later.
module tb_game_redo;

   localparam int N     = 134;
   localparam int DEPTH = 3;
   localparam int CW    = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          game_state_en = 1'b0;
   logic [1:0]    sel = 2'd0;
   logic          real_retract = 1'b0;
   logic [N-1:0]  game_state_now = '0;
   logic          redo_req = 1'b0;
   logic          redo_ack = 1'b0;
   logic [N-1:0]  redo_state;
   logic          redo_valid;
   logic          redo_nack;
   logic [CW-1:0] redo_count;

   typedef struct {
      logic          v;
      logic          nk;
      logic [CW-1:0] cnt;
      logic [N-1:0]  st;
      string         tag;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_err = 0;

   logic [N-1:0] A, B, C, D, E;

   game_redo #(.N(N), .DEPTH(DEPTH), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n), .game_state_en(game_state_en), .sel(sel),
      .real_retract(real_retract), .game_state_now(game_state_now),
      .redo_req(redo_req), .redo_ack(redo_ack), .redo_state(redo_state),
      .redo_valid(redo_valid), .redo_nack(redo_nack), .redo_count(redo_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [N-1:0] act, input logic [N-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [N-1:0] rnd();
      logic [159:0] t;
      t = {$urandom, $urandom, $urandom, $urandom, $urandom};
      return t[N-1:0];
   endfunction

   // Drive one cycle of stimulus, queue the expected outputs, compare after the edge.
   task automatic step(input string tag, input logic en, input logic [1:0] s,
                       input logic rr, input logic [N-1:0] now, input logic req,
                       input logic ack, input logic ev, input logic enk,
                       input logic [CW-1:0] ecnt, input logic [N-1:0] est);
      exp_t e;
      game_state_en  = en;
      sel            = s;
      real_retract   = rr;
      game_state_now = now;
      redo_req       = req;
      redo_ack       = ack;
      e.v = ev; e.nk = enk; e.cnt = ecnt; e.st = est; e.tag = tag;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk({e.tag, ".valid"}, N'(redo_valid), N'(e.v));
      chk({e.tag, ".nack"},  N'(redo_nack),  N'(e.nk));
      chk({e.tag, ".count"}, N'(redo_count), N'(e.cnt));
      chk({e.tag, ".state"}, redo_state, e.st);
   endtask

   task automatic idle(input string tag, input logic ev, input logic [CW-1:0] ecnt,
                       input logic [N-1:0] est);
      step(tag, 1'b0, 2'd0, 1'b0, '0, 1'b0, 1'b0, ev, 1'b0, ecnt, est);
   endtask

   initial begin
      A = rnd(); B = rnd(); C = rnd(); D = rnd(); E = rnd();

      #3;
      chk("rst.valid", N'(redo_valid), '0);
      chk("rst.count", N'(redo_count), '0);
      chk("rst.state", redo_state, '0);
      chk("rst.nack",  N'(redo_nack),  '0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // three retracts, redo presents C, pop exposes B
      step("t2.pushA", 1, 2'd3, 1, A, 0, 0, 0, 0, 2'd1, A);
      step("t2.pushB", 1, 2'd3, 1, B, 0, 0, 0, 0, 2'd2, B);
      step("t2.pushC", 1, 2'd3, 1, C, 0, 0, 0, 0, 2'd3, C);
      step("t2.req",   0, 2'd0, 0, '0, 1, 0, 1, 0, 2'd3, C);
      idle("t2.hold", 1, 2'd3, C);
      step("t2.ackNoEn", 0, 2'd1, 0, '0, 0, 1, 1, 0, 2'd3, C);
      step("t2.pop",   1, 2'd1, 0, '0, 0, 1, 0, 0, 2'd2, B);

      // async reset in the middle of a presentation
      step("t1.req",   0, 2'd0, 0, '0, 1, 0, 1, 0, 2'd2, B);
      redo_req = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("t1.async.valid", N'(redo_valid), '0);
      chk("t1.async.count", N'(redo_count), '0);
      chk("t1.async.state", redo_state, '0);
      #2 rst_n = 1'b1;
      step("t1.nack",  0, 2'd0, 0, '0, 1, 0, 0, 1, 2'd0, '0);
      idle("t1.nackEnd", 0, 2'd0, '0);

      // overflow drops the oldest entry
      step("t3.pushA", 1, 2'd3, 1, A, 0, 0, 0, 0, 2'd1, A);
      step("t3.pushB", 1, 2'd3, 1, B, 0, 0, 0, 0, 2'd2, B);
      step("t3.pushC", 1, 2'd3, 1, C, 0, 0, 0, 0, 2'd3, C);
      step("t3.pushD", 1, 2'd3, 1, D, 0, 0, 0, 0, 2'd3, D);
      step("t3.req1",  0, 2'd0, 0, '0, 1, 0, 1, 0, 2'd3, D);
      step("t3.pop1",  1, 2'd2, 0, '0, 0, 1, 0, 0, 2'd2, C);
      step("t3.req2",  0, 2'd0, 0, '0, 1, 0, 1, 0, 2'd2, C);
      // held request re-presents one cycle after the pop
      step("t3.pop2",  1, 2'd2, 0, '0, 1, 1, 0, 0, 2'd1, B);
      step("t3.rereq", 0, 2'd0, 0, '0, 1, 0, 1, 0, 2'd1, B);
      step("t3.pop3",  1, 2'd1, 0, '0, 0, 1, 0, 0, 2'd0, '0);
      step("t3.req4",  0, 2'd0, 0, '0, 1, 0, 0, 1, 2'd0, '0);
      idle("t3.end", 0, 2'd0, '0);

      // a move clears history
      step("t4.pushA", 1, 2'd3, 1, A, 0, 0, 0, 0, 2'd1, A);
      step("t4.move",  1, 2'd2, 0, '0, 0, 0, 0, 0, 2'd0, '0);
      step("t4.req",   0, 2'd0, 0, '0, 1, 0, 0, 1, 2'd0, '0);
      // ack in IDLE is a plain move: clears
      step("t4.pushB", 1, 2'd3, 1, B, 0, 0, 0, 0, 2'd1, B);
      step("t4.ackIdle", 1, 2'd1, 0, '0, 0, 1, 0, 0, 2'd0, '0);

      // no-op retract, then init clears PRESENT
      step("t5.pushA", 1, 2'd3, 1, A, 0, 0, 0, 0, 2'd1, A);
      step("t5.noop",  1, 2'd3, 0, B, 0, 0, 0, 0, 2'd1, A);
      step("t5.req",   0, 2'd0, 0, '0, 1, 0, 1, 0, 2'd1, A);
      step("t5.init",  1, 2'd0, 0, '0, 0, 0, 0, 0, 2'd0, '0);

      // push while presenting keeps valid and shows the new top
      step("t6.pushA", 1, 2'd3, 1, A, 0, 0, 0, 0, 2'd1, A);
      step("t6.req",   0, 2'd0, 0, '0, 1, 0, 1, 0, 2'd1, A);
      step("t6.pushE", 1, 2'd3, 1, E, 0, 0, 1, 0, 2'd2, E);
      step("t6.pop",   1, 2'd1, 0, '0, 0, 1, 0, 0, 2'd1, A);
      idle("t6.end", 0, 2'd1, A);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
